// File: rtl/prog_loader_if.sv
// Upstream word stream and instruction-memory write port of the program loader.
// The slave side is the loader, the master side is the word source and memory.
interface prog_loader_if #(
  parameter int D = 10
);
  logic         in_valid;
  logic [8:0]   in_data;
  logic         in_ready;
  logic         imem_we;
  logic [D-1:0] imem_addr;
  logic [8:0]   imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot/run controller: loads machine code into imem with the core held in reset, then runs it under a cycle budget.
// Optional XOR checksum of loaded words is built only when PROG_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LOAD  | accepting words into imem, core held in reset
// PREP  | single reset cycle so the core sees reset at a clock edge
// RUN   | core released, cycles counted
// HALT  | run ended, core frozen, results held
module prog_loader #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  len,
  input  logic [CW-1:0] max_cycles,
  prog_loader_if.slave  bus,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [8:0]    checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [D-1:0]  ONE_D  = D'(1);
  localparam logic [CW-1:0] ONE_CW = CW'(1);

  state_t        state;
  state_t        state_d;
  logic [D-1:0]  len_q;
  logic [D-1:0]  word_cnt;
  logic [CW-1:0] max_q;
  logic [CW:0]   cycles_inc;
  logic          accept;
  logic          wr;
  logic          last_word;
  logic          budget_hit;
  logic          run_tick;
  logic          set_fin;
  logic          set_to;

  assign bus.in_ready   = (state == S_LOAD);
  assign wr             = bus.in_valid & (state == S_LOAD);
  assign bus.imem_we    = wr;
  assign bus.imem_addr  = word_cnt;
  assign bus.imem_wdata = bus.in_data;

  assign last_word  = (word_cnt == (len_q - ONE_D));
  // One bit wider so a saturated counter never aliases onto the budget.
  assign cycles_inc = {1'b0, cycles} + {{CW{1'b0}}, 1'b1};
  assign budget_hit = (max_q != '0) && (cycles_inc == {1'b0, max_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    run_tick   = 1'b0;
    set_fin    = 1'b0;
    set_to     = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len != '0) ? S_LOAD : S_PREP;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (bus.in_valid && last_word) begin
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        busy    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        run_tick   = 1'b1;
        // done wins over an expiring budget in the same cycle
        if (core_done) begin
          set_fin = 1'b1;
          state_d = S_HALT;
        end else if (budget_hit) begin
          set_to  = 1'b1;
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      max_q    <= '0;
      word_cnt <= '0;
      cycles   <= '0;
      finished <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (accept) begin
        len_q    <= len;
        max_q    <= max_cycles;
        word_cnt <= '0;
        cycles   <= '0;
        finished <= 1'b0;
        timeout  <= 1'b0;
      end
      if (wr) begin
        word_cnt <= word_cnt + ONE_D;
      end
      if (run_tick && (cycles != '1)) begin
        cycles <= cycles + ONE_CW;
      end
      if (set_fin) begin
        finished <= 1'b1;
      end
      if (set_to) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [8:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (wr) begin
      csum_q <= csum_q ^ bus.in_data;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a write/run model derived from the load and budget rules,
// a per-cycle monitor, and literal expectations for the documented scenarios.
module tb_prog_loader;
  localparam int D  = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [D-1:0]  len;
  logic [CW-1:0] max_cycles;
  logic          core_reset;
  logic          core_done;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [8:0]    checksum;

  prog_loader_if #(.D(D)) bus();

  prog_loader #(.D(D), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .max_cycles (max_cycles),
    .bus        (bus),
    .core_reset (core_reset),
    .core_done  (core_done),
    .busy       (busy),
    .finished   (finished),
    .timeout    (timeout),
    .cycles     (cycles),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Core stand-in: raises done in its done_at-th cycle out of reset (0 = never).
  int cyc      = 0;
  int run_seen = 0;
  int done_at  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_reset) run_seen <= 0;
    else            run_seen <= run_seen + 1;
  end

  assign core_done = !core_reset && (done_at != 0) && (run_seen + 1 == done_at);

  // Model: the i-th write of a load goes to address i carrying the i-th word.
  logic [8:0] exp_data [0:1023];
  logic [8:0] words    [0:15];
  int exp_base      = 0;
  int wr_total      = 0;
  int run_total     = 0;
  int first_wr_cyc  = -1;
  int last_wr_cyc   = -1;
  int run_start_cyc = -1;
  int acc           = 0;

  initial begin : monitor
    logic prev_cr;
    int   idx;
    prev_cr = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!bus.in_valid) chk("no_write_when_invalid", 32'(bus.imem_we), 0);
        if (!busy)         chk("ready_low_when_idle", 32'(bus.in_ready), 0);
        if (bus.imem_we) begin
          idx = wr_total - exp_base;
          if (idx < 0 || idx > 1023) begin
            chk("write_in_range", 0, 1);
          end else begin
            chk("write_addr", 32'(bus.imem_addr), idx);
            chk("write_data", 32'(bus.imem_wdata), 32'(exp_data[idx]));
          end
          if (idx == 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          wr_total++;
        end
        if (!core_reset) begin
          if (prev_cr) run_start_cyc = cyc;
          run_total++;
          chk("busy_in_run", 32'(busy), 1);
        end
      end
      prev_cr = core_reset;
    end
  end

  task automatic push_word(input logic [8:0] w, input int gap);
    int   guard;
    logic rdy;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    guard = 0;
    do begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("word_accepted_in_time", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_case(input string tag, input int n, input int gap,
                          input logic [CW-1:0] budget, input int dn, input int poke_at);
    logic [8:0] xr;
    int  wr_before, runs_before, exp_run, guard, seen;
    bit  exp_fin, poked;
    exp_base    = wr_total;
    wr_before   = wr_total;
    runs_before = run_total;
    xr = '0;
    for (int i = 0; i < n; i++) begin
      exp_data[i] = words[i];
      xr ^= words[i];
    end
    exp_fin = (dn != 0) && (budget == 0 || dn <= int'(budget));
    exp_run = exp_fin ? dn : int'(budget);
    done_at = dn;

    start = 1'b1; len = n[D-1:0]; max_cycles = budget;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    chk({tag, "_finished_cleared"}, 32'(finished), 0);
    chk({tag, "_timeout_cleared"}, 32'(timeout), 0);
    chk({tag, "_cycles_cleared"}, 32'(cycles), 0);
    chk({tag, "_checksum_cleared"}, 32'(checksum), 0);

    for (int i = 0; i < n; i++) push_word(words[i], (i == 0) ? 0 : gap);

    guard = 0; seen = 0; poked = 0;
    while (!(finished || timeout) && guard < 400) begin
      if (poked) begin
        start = 1'b0; poked = 0;
        chk({tag, "_start_ignored_run"}, 32'(core_reset), 0);
        chk({tag, "_start_ignored_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_start_ignored_cycles"}, 32'(cycles), poke_at);
      end
      if (!core_reset) begin
        seen++;
        if (poke_at != 0 && seen == poke_at) begin
          start = 1'b1; len = 10'd5; poked = 1;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (guard >= 400) chk({tag, "_halt_reached"}, 0, 1);

    chk({tag, "_write_count"}, wr_total - wr_before, n);
    if (n > 0) begin
      chk({tag, "_first_write_cycle"}, first_wr_cyc, acc);
      chk({tag, "_run_start_cycle"}, run_start_cyc, last_wr_cyc + 2);
    end else begin
      chk({tag, "_run_start_cycle"}, run_start_cyc, acc + 1);
    end
    chk({tag, "_run_cycles"}, run_total - runs_before, exp_run);
    chk({tag, "_cycles"}, 32'(cycles), exp_run);
    chk({tag, "_finished"}, 32'(finished), 32'(exp_fin));
    chk({tag, "_timeout"}, 32'(timeout), 32'(!exp_fin));
    chk({tag, "_core_reset_halt"}, 32'(core_reset), 1);
    chk({tag, "_busy_halt"}, 32'(busy), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 32'(xr));
`else
    chk({tag, "_checksum"}, 32'(checksum), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_cycles_held"}, 32'(cycles), exp_run);
    chk({tag, "_finished_held"}, 32'(finished), 32'(exp_fin));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0; len = '0; max_cycles = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_imem_we", 32'(bus.imem_we), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cycles", 32'(cycles), 0);
    chk("rst_checksum", 32'(checksum), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Load three words, core hits all-ones on its 3rd cycle.
    words[0] = 9'h0A1; words[1] = 9'h012; words[2] = 9'h1FF;
    run_case("load_run", 3, 0, 16'd0, 3, 0);
    chk("load_run_lit_cycles", 32'(cycles), 3);
    chk("load_run_lit_run_start", run_start_cyc, acc + 4);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("load_run_lit_checksum", 32'(checksum), 32'h14C);
`else
    chk("load_run_lit_checksum", 32'(checksum), 0);
`endif

    // Four idle cycles between the two words.
    words[0] = 9'h155; words[1] = 9'h0AA;
    run_case("gaps", 2, 4, 16'd0, 1, 0);
    chk("gaps_lit_last_write", last_wr_cyc, acc + 5);

    run_case("budget", 0, 0, 16'd5, 0, 0);
    chk("budget_lit_cycles", 32'(cycles), 5);
    chk("budget_lit_timeout", 32'(timeout), 1);

    words[0] = 9'h003;
    run_case("done_and_budget", 1, 0, 16'd4, 4, 0);
    chk("done_and_budget_lit_fin", 32'(finished), 1);
    chk("done_and_budget_lit_to", 32'(timeout), 0);

    run_case("ignore_start", 0, 0, 16'd0, 10, 3);
    chk("ignore_start_lit_cycles", 32'(cycles), 10);

    // Restart out of HALT with a longer program and a budget that does not bite.
    for (int i = 0; i < 5; i++) words[i] = 9'(i * 37 + 1);
    run_case("restart", 5, 1, 16'd20, 7, 0);

    // Reset after three of eight words.
    for (int i = 0; i < 8; i++) begin
      words[i] = 9'(9'h100 + i);
      exp_data[i] = words[i];
    end
    exp_base = wr_total;
    done_at = 0;
    start = 1'b1; len = 10'd8; max_cycles = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) push_word(words[i], 0);
    chk("midload_written", wr_total - exp_base, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midload_in_ready", 32'(bus.in_ready), 0);
    chk("midload_core_reset", 32'(core_reset), 1);
    chk("midload_cycles", 32'(cycles), 0);
    chk("midload_busy", 32'(busy), 0);
    chk("midload_imem_addr", 32'(bus.imem_addr), 0);
    chk("midload_checksum", 32'(checksum), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    words[0] = 9'h1C3; words[1] = 9'h03C;
    run_case("after_reset", 2, 0, 16'd0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
